cpu_control_pipe: RTL and testbench

Parametrised pipelined control unit for the RV32I core. Decodes the instruction in ID into an `rv32i_control_word`, then carries it down a configurable number of registered stages (ID/EX onward) with stall, flush and bubble insertion. Detects load-use hazards against the ID/EX stage and flags illegal encodings. Replaces the purely combinational decoder in the pipelined datapath.

---
 rtl/cpu_control_pipe_pkg.sv | 55 +++++
 rtl/cpu_control_pipe_decode.sv | 137 +++++++++++++
 rtl/cpu_control_pipe.sv | 83 ++++++++
 tb/tb_cpu_control_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_pipe_pkg.sv
// RV32I control-word types shared by the decoder, the control pipe and its bench.
package cpu_control_pipe_pkg;

  localparam int MAX_CTRL_STAGES = 6;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  // Encodings line up with funct3 so and/or/xor/sll/srl pass straight through.
  typedef enum logic [2:0] {
    alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
  } alu_ops;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic       {a1_rs1, a1_pc} alumux1_sel_t;
  typedef enum logic [2:0] {a2_i_imm, a2_u_imm, a2_b_imm, a2_s_imm, a2_j_imm, a2_rs2} alumux2_sel_t;
  typedef enum logic [3:0] {
    rf_alu, rf_br_en, rf_u_imm, rf_lw, rf_pc4, rf_lb, rf_lbu, rf_lh, rf_lhu
  } regfilemux_sel_t;
  typedef enum logic       {cm_rs2, cm_i_imm} cmpmux_sel_t;

  typedef struct packed {
    rv32i_opcode     opcode;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    cmpmux_sel_t     cmpmux_sel;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            muldiv;
    logic [2:0]      muldiv_op;
  } rv32i_control_word;

  localparam rv32i_control_word CTRL_BUBBLE = '0;

endpackage

// File: rtl/cpu_control_pipe_decode.sv
// Combinational RV32I decoder: control word, register-use flags, illegal flag; 0 cycles, no flow control.
// CTRL_RV32M_EN makes op_reg with funct7 = 0x01 a legal mul/div operation.
module cpu_control_decode
  import cpu_control_pipe_pkg::*;
(
  input  rv32i_opcode       i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [4:0]        i_rd,
  output rv32i_control_word o_cword,
  output logic              o_uses_rs1,
  output logic              o_uses_rs2,
  output logic              o_illegal
);

  rv32i_control_word w_cw;
  logic              w_rs1;
  logic              w_rs2;
  logic              w_ill;
  logic              w_m_ok;

`ifdef CTRL_RV32M_EN
  assign w_m_ok = (i_funct7 == 7'h01);
`else
  assign w_m_ok = 1'b0;
`endif

  always_comb begin
    w_cw        = CTRL_BUBBLE;
    w_cw.opcode = i_opcode;
    w_cw.funct3 = i_funct3;
    w_cw.rd     = i_rd;
    w_rs1       = 1'b0;
    w_rs2       = 1'b0;
    w_ill       = 1'b0;
    case (i_opcode)
      op_lui: begin
        w_cw.load_regfile   = 1'b1;
        w_cw.regfilemux_sel = rf_u_imm;
      end
      op_auipc: begin
        w_cw.load_regfile = 1'b1;
        w_cw.alumux1_sel  = a1_pc;
        w_cw.alumux2_sel  = a2_u_imm;
      end
      op_jal: begin
        w_cw.jump           = 1'b1;
        w_cw.load_regfile   = 1'b1;
        w_cw.alumux1_sel    = a1_pc;
        w_cw.alumux2_sel    = a2_j_imm;
        w_cw.regfilemux_sel = rf_pc4;
      end
      op_jalr: begin
        w_rs1               = 1'b1;
        w_cw.jump           = 1'b1;
        w_cw.load_regfile   = 1'b1;
        w_cw.regfilemux_sel = rf_pc4;
      end
      op_br: begin
        w_rs1            = 1'b1;
        w_rs2            = 1'b1;
        w_cw.branch      = 1'b1;
        w_cw.cmpop       = branch_funct3_t'(i_funct3);
        w_cw.alumux1_sel = a1_pc;
        w_cw.alumux2_sel = a2_b_imm;
      end
      op_load: begin
        w_rs1             = 1'b1;
        w_cw.mem_read     = 1'b1;
        w_cw.load_regfile = 1'b1;
        case (i_funct3)
          3'b000:  w_cw.regfilemux_sel = rf_lb;
          3'b001:  w_cw.regfilemux_sel = rf_lh;
          3'b100:  w_cw.regfilemux_sel = rf_lbu;
          3'b101:  w_cw.regfilemux_sel = rf_lhu;
          default: w_cw.regfilemux_sel = rf_lw;
        endcase
      end
      op_store: begin
        w_rs1            = 1'b1;
        w_rs2            = 1'b1;
        w_cw.mem_write   = 1'b1;
        w_cw.alumux2_sel = a2_s_imm;
      end
      op_imm: begin
        w_rs1             = 1'b1;
        w_cw.load_regfile = 1'b1;
        case (i_funct3)
          3'b010: begin
            w_cw.cmpop = blt; w_cw.cmpmux_sel = cm_i_imm; w_cw.regfilemux_sel = rf_br_en;
          end
          3'b011: begin
            w_cw.cmpop = bltu; w_cw.cmpmux_sel = cm_i_imm; w_cw.regfilemux_sel = rf_br_en;
          end
          3'b101:  w_cw.aluop = i_funct7[5] ? alu_sra : alu_srl;
          default: w_cw.aluop = alu_ops'(i_funct3);
        endcase
      end
      op_reg: begin
        w_rs1             = 1'b1;
        w_rs2             = 1'b1;
        w_cw.load_regfile = 1'b1;
        w_cw.alumux2_sel  = a2_rs2;
        if (w_m_ok) begin
          w_cw.muldiv    = 1'b1;
          w_cw.muldiv_op = i_funct3;
        end else if (i_funct7 != 7'h00 && i_funct7 != 7'h20) begin
          w_ill = 1'b1;
        end else if (i_funct7[5] && i_funct3 != 3'b000 && i_funct3 != 3'b101) begin
          w_ill = 1'b1;
        end else begin
          case (i_funct3)
            3'b000:  w_cw.aluop = i_funct7[5] ? alu_sub : alu_add;
            3'b010:  begin w_cw.cmpop = blt;  w_cw.regfilemux_sel = rf_br_en; end
            3'b011:  begin w_cw.cmpop = bltu; w_cw.regfilemux_sel = rf_br_en; end
            3'b101:  w_cw.aluop = i_funct7[5] ? alu_sra : alu_srl;
            default: w_cw.aluop = alu_ops'(i_funct3);
          endcase
        end
      end
      default: w_ill = 1'b1;
    endcase
    if (i_rd == 5'd0) w_cw.load_regfile = 1'b0;
    // Illegal encodings become bubbles and never create a load-use stall.
    if (w_ill) begin
      w_cw  = CTRL_BUBBLE;
      w_rs1 = 1'b0;
      w_rs2 = 1'b0;
    end
  end

  assign o_cword    = w_cw;
  assign o_uses_rs1 = w_rs1;
  assign o_uses_rs2 = w_rs2;
  assign o_illegal  = w_ill;

endmodule

// File: rtl/cpu_control_pipe.sv
// Pipelined control: decode in ID, STAGES registered control stages with stall/flush/load-use bubbles.
// Decode-to-stage-0 latency 1 cycle; i_stall_in freezes all stages; CTRL_RV32M_EN enables mul/div decode.
module cpu_control_pipe
  import cpu_control_pipe_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  rv32i_opcode       i_opcode,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic              i_stall_in,
  input  logic              i_flush,
  output rv32i_control_word o_cword_q [STAGES],
  output logic [STAGES-1:0] o_valid_q,
  output logic              o_hazard_stall,
  output logic              o_illegal_q
);

  rv32i_control_word r_cword [STAGES];
  logic [STAGES-1:0] r_valid;
  logic              r_illegal;

  rv32i_control_word w_dec_cword;
  logic              w_uses_rs1;
  logic              w_uses_rs2;
  logic              w_dec_illegal;
  logic              w_hazard;
  rv32i_control_word w_s0_cword;
  logic              w_s0_valid;
  logic              w_illegal_nxt;

  cpu_control_decode u_decode (
    .i_opcode   (i_opcode),
    .i_funct3   (i_funct3),
    .i_funct7   (i_funct7),
    .i_rd       (i_rd),
    .o_cword    (w_dec_cword),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_illegal  (w_dec_illegal)
  );

  assign w_hazard = i_id_valid & r_valid[0] & r_cword[0].mem_read & (r_cword[0].rd != 5'd0) &
                    ((w_uses_rs1 & (i_rs1 == r_cword[0].rd)) |
                     (w_uses_rs2 & (i_rs2 == r_cword[0].rd)));

  // Flush outranks the hazard; both insert a bubble and drop the ID instruction.
  always_comb begin
    w_s0_cword    = CTRL_BUBBLE;
    w_s0_valid    = 1'b0;
    w_illegal_nxt = 1'b0;
    if (!i_flush && !w_hazard && i_id_valid) begin
      w_s0_cword    = w_dec_cword;
      w_s0_valid    = !w_dec_illegal;
      w_illegal_nxt = w_dec_illegal;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) r_cword[k] <= CTRL_BUBBLE;
      r_valid   <= '0;
      r_illegal <= 1'b0;
    end else if (!i_stall_in) begin
      r_cword[0] <= w_s0_cword;
      for (int k = 1; k < STAGES; k++) r_cword[k] <= r_cword[k-1];
      r_valid   <= {r_valid[STAGES-2:0], w_s0_valid};
      r_illegal <= w_illegal_nxt;
    end
  end

  assign o_cword_q      = r_cword;
  assign o_valid_q      = r_valid;
  assign o_hazard_stall = w_hazard;
  assign o_illegal_q    = r_illegal;

endmodule

// File: tb/tb_cpu_control_pipe.sv
// Directed bench for cpu_control_pipe (STAGES = 3); expectations follow CTRL_RV32M_EN when defined.
module tb_cpu_control_pipe;
  import cpu_control_pipe_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  rv32i_opcode       opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd, rs1, rs2;
  logic              stall_in;
  logic              flush;
  rv32i_control_word cword_q [3];
  logic [2:0]        valid_q;
  logic              hazard_stall;
  logic              illegal_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_control_pipe #(.STAGES(3)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_valid     (id_valid),
    .i_opcode       (opcode),
    .i_funct3       (funct3),
    .i_funct7       (funct7),
    .i_rd           (rd),
    .i_rs1          (rs1),
    .i_rs2          (rs2),
    .i_stall_in     (stall_in),
    .i_flush        (flush),
    .o_cword_q      (cword_q),
    .o_valid_q      (valid_q),
    .o_hazard_stall (hazard_stall),
    .o_illegal_q    (illegal_q)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drv(input logic v, input rv32i_opcode op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2);
    id_valid = v; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
    drv(1'b0, op_imm, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    check("rst_valid", valid_q, 3'b000);
    check("rst_illegal", illegal_q, 1'b0);
    check("rst_hazard", hazard_stall, 1'b0);
    check("rst_ctrl", {cword_q[0].load_regfile, cword_q[1].mem_read, cword_q[2].mem_write,
                       cword_q[0].branch, cword_q[1].jump}, 5'b0);
    rst = 1'b0;

    // addi x1,x0,5 travels ID/EX -> stage 2
    drv(1'b1, op_imm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0);
    tick();
    check("addi_valid", valid_q, 3'b001);
    check("addi_aluop", cword_q[0].aluop, alu_add);
    check("addi_lr", cword_q[0].load_regfile, 1'b1);
    check("addi_mux2", cword_q[0].alumux2_sel, a2_i_imm);
    drv(1'b0, op_imm, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    check("addi_s2_valid", valid_q, 3'b100);
    check("addi_s2_rd", cword_q[2].rd, 5'd1);

    // lw x5,0(x2) ; add x6,x5,x3
    drv(1'b1, op_load, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0);
    tick();
    check("lw_memrd", cword_q[0].mem_read, 1'b1);
    check("lw_rfmux", cword_q[0].regfilemux_sel, rf_lw);
    drv(1'b1, op_reg, 3'd0, 7'd0, 5'd6, 5'd5, 5'd3);
    check("lu_hazard", hazard_stall, 1'b1);
    tick();
    check("lu_bubble_valid", valid_q, 3'b010);
    check("lu_hazard_drop", hazard_stall, 1'b0);
    check("lu_lw_s1", cword_q[1].rd, 5'd5);
    tick();
    check("lu_add_valid", valid_q, 3'b101);
    check("lu_add_rd", cword_q[0].rd, 5'd6);
    check("lu_lw_s2", cword_q[2].mem_read, 1'b1);

    // lw x0 ; use of x0: no stall
    drv(1'b1, op_load, 3'b010, 7'd0, 5'd0, 5'd2, 5'd0);
    tick();
    drv(1'b1, op_reg, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0);
    check("x0_no_hazard", hazard_stall, 1'b0);
    tick();
    check("x0_add_in", {valid_q[0], cword_q[0].rd}, {1'b1, 5'd7});

    // rs2 dependency via store; jal ignores its rs1 field
    drv(1'b1, op_load, 3'b010, 7'd0, 5'd9, 5'd2, 5'd0);
    tick();
    drv(1'b1, op_store, 3'b010, 7'd0, 5'd0, 5'd4, 5'd9);
    check("sw_rs2_hazard", hazard_stall, 1'b1);
    drv(1'b1, op_jal, 3'd0, 7'd0, 5'd1, 5'd9, 5'd9);
    check("jal_no_hazard", hazard_stall, 1'b0);
    drv(1'b0, op_imm, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();

    // flush together with a load-use hazard
    drv(1'b1, op_load, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0);
    tick();
    flush = 1'b1;
    drv(1'b1, op_reg, 3'd0, 7'd0, 5'd6, 5'd5, 5'd3);
    check("fl_hazard", hazard_stall, 1'b1);
    tick();
    check("fl_valid", valid_q[1:0], 2'b10);
    check("fl_illegal", illegal_q, 1'b0);
    flush = 1'b0;
    drv(1'b0, op_imm, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    check("fl_no_dup", valid_q, 3'b100);

    // illegal opcode: one advance of illegal_q, flush suppresses it
    drv(1'b1, rv32i_opcode'(7'h7f), 3'd0, 7'd0, 5'd3, 5'd0, 5'd0);
    tick();
    check("ill_flag", illegal_q, 1'b1);
    check("ill_bubble", {valid_q[0], cword_q[0].load_regfile}, 2'b00);
    drv(1'b1, op_imm, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0);
    tick();
    check("ill_clear", {illegal_q, valid_q[0]}, 2'b01);
    flush = 1'b1;
    drv(1'b1, rv32i_opcode'(7'h7f), 3'd0, 7'd0, 5'd3, 5'd0, 5'd0);
    tick();
    check("ill_flushed", illegal_q, 1'b0);
    flush = 1'b0;

    // funct7 checks on reg/imm ops, lui to x0
    drv(1'b1, op_reg, 3'b111, 7'h20, 5'd8, 5'd1, 5'd2);
    tick();
    check("and_f7_ill", illegal_q, 1'b1);
    drv(1'b1, op_reg, 3'b000, 7'h20, 5'd8, 5'd1, 5'd2);
    tick();
    check("sub_aluop", {illegal_q, cword_q[0].aluop}, {1'b0, alu_sub});
    drv(1'b1, op_imm, 3'b101, 7'h20, 5'd8, 5'd1, 5'd0);
    tick();
    check("srai_aluop", cword_q[0].aluop, alu_sra);
    drv(1'b1, op_lui, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    check("lui_x0", {valid_q[0], cword_q[0].load_regfile}, 2'b10);

    // stall_in for 3 cycles, then reset during the stall
    drv(1'b1, op_imm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0);
    tick();
    drv(1'b1, op_imm, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0);
    tick();
    stall_in = 1'b1;
    drv(1'b1, op_imm, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", valid_q, 3'b111);
      check("stall_rds", {cword_q[0].rd, cword_q[1].rd, cword_q[2].rd}, {5'd2, 5'd1, 5'd0});
      check("stall_lr", {cword_q[0].load_regfile, cword_q[1].load_regfile}, 2'b11);
    end
    rst = 1'b1;
    tick();
    check("stall_rst_valid", valid_q, 3'b000);
    check("stall_rst_lr", cword_q[0].load_regfile, 1'b0);
    rst = 1'b0; stall_in = 1'b0;

    // hazard stays asserted across a stall
    drv(1'b1, op_load, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0);
    tick();
    stall_in = 1'b1;
    drv(1'b1, op_reg, 3'd0, 7'd0, 5'd6, 5'd5, 5'd3);
    check("hs_hazard", hazard_stall, 1'b1);
    tick();
    check("hs_hazard_held", {hazard_stall, valid_q}, {1'b1, 3'b001});
    stall_in = 1'b0;
    tick();
    check("hs_release", {hazard_stall, valid_q}, {1'b0, 3'b010});

    // funct7 = 0x01 on op_reg
    drv(1'b1, op_reg, 3'b110, 7'h01, 5'd8, 5'd1, 5'd2);
    tick();
`ifdef CTRL_RV32M_EN
    check("m_valid", {illegal_q, valid_q[0]}, 2'b01);
    check("m_muldiv", {cword_q[0].muldiv, cword_q[0].muldiv_op}, {1'b1, 3'b110});
`else
    check("m_illegal", {illegal_q, valid_q[0]}, 2'b10);
    check("m_muldiv", cword_q[0].muldiv, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
